// File: rtl/irq_stack_ctrl.sv
// irq_stack_ctrl: interrupt entry/return sequencer for the return-address
// stack. Arbitrates push/pop between call/ret/reti and interrupt entry,
// latches and masks IRQ edges, and tracks stack occupancy.
//
// Handshake: there is no ready/valid back-pressure. A strobe
// (stack_push, stack_pop, take_vector, ack) is valid in the cycle it is
// high and is consumed by the stack/CPU at the next rising edge of clk.
module irq_stack_ctrl #(
  parameter int                NIRQ       = 4,
  parameter int                PC_W       = 10,
  parameter int                DEPTH      = 16,
  parameter logic [PC_W-1:0]   VEC_BASE   = 10'h3C0,
  parameter int                VEC_STRIDE = 16,
  localparam int               ID_W       = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  input  logic            call,
  input  logic            ret,
  input  logic            reti,
  input  logic [PC_W-1:0] pc_addr,
  output logic            stack_push,
  output logic            stack_pop,
  output logic            stack_interrupt,
  output logic [PC_W-1:0] stack_data,
  output logic            take_vector,
  output logic [PC_W-1:0] pc_vector,
  output logic [NIRQ-1:0] ack,
  output logic            in_isr,
  output logic [ID_W-1:0] active_id,
  output logic [4:0]      depth,
  output logic            error
);

  typedef enum logic {IDLE = 1'b0, ISR = 1'b1} state_t;

  state_t          state;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] irq_prev;
  logic [4:0]      isr_calls;

  logic [NIRQ-1:0] req;
  logic [ID_W-1:0] sel_id;
  logic [31:0]     vec_off;
  logic            multi_op;
  logic            not_full;
  logic            not_empty;
  logic            entry;
  logic            call_ok;
  logic            ret_ok;
  logic            reti_ok;
  logic            misuse;

  // Lowest-index enabled pending request wins arbitration.
  always_comb begin
    req    = pending & mask;
    sel_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) sel_id = ID_W'(i);
    end
  end

  // Decode the legal actions of this cycle and drive the combinational strobes.
  always_comb begin
    multi_op  = (call & ret) | (call & reti) | (ret & reti);
    not_full  = (depth < 5'(DEPTH));
    not_empty = (depth != 5'd0);

    call_ok = !reset && call && !multi_op && not_full;
    ret_ok  = !reset && ret && !multi_op && not_empty &&
              ((state == IDLE) || (isr_calls != 5'd0));
    reti_ok = !reset && reti && !multi_op && (state == ISR) &&
              (isr_calls == 5'd0);
    // Any CPU stack instruction in this cycle (even an illegal one) blocks entry.
    entry   = !reset && (state == IDLE) && (req != '0) &&
              !call && !ret && !reti && not_full;
    misuse  = !reset && (multi_op || (call && !call_ok) ||
                         (ret && !ret_ok) || (reti && !reti_ok));

    stack_push      = call_ok | entry;
    stack_pop       = ret_ok | reti_ok;
    stack_interrupt = reti_ok;
    stack_data      = pc_addr;
    take_vector     = entry;

    vec_off   = 32'(sel_id) * 32'(VEC_STRIDE);
    pc_vector = VEC_BASE + vec_off[PC_W-1:0];

    ack = '0;
    if (entry) ack[sel_id] = 1'b1;
  end

  assign in_isr = (state == ISR);

  // Sequencer state, occupancy counters, pending/mask registers and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      mask      <= '0;
      irq_prev  <= '0;
      depth     <= 5'd0;
      isr_calls <= 5'd0;
      active_id <= '0;
      error     <= 1'b0;
    end else begin
      irq_prev <= irq;
      // A fresh edge in the ack cycle re-arms the request.
      pending  <= (pending & ~ack) | (irq & ~irq_prev);
      if (mask_we) mask <= mask_wdata;
      if (misuse)  error <= 1'b1;

      if (stack_push)     depth <= depth + 5'd1;
      else if (stack_pop) depth <= depth - 5'd1;

      if (call_ok && state == ISR)     isr_calls <= isr_calls + 5'd1;
      else if (ret_ok && state == ISR) isr_calls <= isr_calls - 5'd1;

      case (state)
        IDLE: if (entry) begin
          state     <= ISR;
          active_id <= sel_id;
        end
        ISR: if (reti_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_stack_ctrl.sv
// tb_irq_stack_ctrl: directed scenarios followed by randomized traffic,
// all compared against a behavioural model built on a PC queue.
module tb_irq_stack_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       call;
  logic       ret;
  logic       reti;
  logic [9:0] pc_addr;

  logic       stack_push;
  logic       stack_pop;
  logic       stack_interrupt;
  logic [9:0] stack_data;
  logic       take_vector;
  logic [9:0] pc_vector;
  logic [3:0] ack;
  logic       in_isr;
  logic [1:0] active_id;
  logic [4:0] depth;
  logic       error;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  irq_stack_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .call(call), .ret(ret), .reti(reti),
    .pc_addr(pc_addr), .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_interrupt(stack_interrupt), .stack_data(stack_data),
    .take_vector(take_vector), .pc_vector(pc_vector), .ack(ack),
    .in_isr(in_isr), .active_id(active_id), .depth(depth), .error(error)
  );

  // ---------------- behavioural reference model ----------------
  int       m_stack[$];   // saved PCs, back = top of stack
  bit       m_isr;
  int       m_calls;      // calls made inside the current ISR
  bit [3:0] m_pend, m_mask, m_prev;
  bit       m_err;
  int       m_aid;

  // expectations for the current cycle
  bit       e_entry, e_call, e_ret, e_reti, e_bad;
  int       e_id;
  bit [3:0] e_ack;
  bit [9:0] e_vec;

  // snapshots of DUT outputs from the last sampled cycle
  logic       s_push, s_pop, s_sint, s_take;
  logic [9:0] s_vec, s_data;
  logic [3:0] s_ack;
  logic       s_isr, s_err;
  logic [4:0] s_depth;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_isr = 0; m_calls = 0; m_pend = 0; m_mask = 0; m_prev = 0;
    m_err = 0; m_aid = 0;
  endtask

  task automatic model_eval();
    int n;
    bit [3:0] req;
    n   = int'(call) + int'(ret) + int'(reti);
    req = m_pend & m_mask;
    e_id = -1;
    for (int i = 3; i >= 0; i--) if (req[i]) e_id = i;
    e_entry = !reset && !m_isr && e_id >= 0 && n == 0 && m_stack.size() < 16;
    e_call  = !reset && n == 1 && call && m_stack.size() < 16;
    e_ret   = !reset && n == 1 && ret && m_stack.size() > 0 && (!m_isr || m_calls > 0);
    e_reti  = !reset && n == 1 && reti && m_isr && m_calls == 0;
    e_bad   = !reset && (n > 1 || (call && !e_call) || (ret && !e_ret) || (reti && !e_reti));
    e_ack   = e_entry ? 4'(1 << e_id) : 4'b0000;
    e_vec   = 10'((32'h3C0 + e_id * 16) & 32'h3FF);
  endtask

  task automatic model_update();
    if (reset) begin
      model_reset();
    end else begin
      if (e_bad) m_err = 1;
      m_pend = (m_pend & ~e_ack) | (irq & ~m_prev);
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
      if (e_entry) begin
        m_stack.push_back(int'(pc_addr));
        m_isr = 1;
        m_aid = e_id;
      end
      if (e_call) begin
        m_stack.push_back(int'(pc_addr));
        if (m_isr) m_calls++;
      end
      if (e_ret) begin
        void'(m_stack.pop_back());
        if (m_isr) m_calls--;
      end
      if (e_reti) begin
        void'(m_stack.pop_back());
        m_isr = 0;
      end
    end
  endtask

  task automatic check_outputs();
    model_eval();
    check("push",  stack_push, e_call | e_entry);
    check("pop",   stack_pop, e_ret | e_reti);
    check("sint",  stack_interrupt, e_reti);
    check("data",  stack_data, pc_addr);
    check("take",  take_vector, e_entry);
    check("ack",   ack, e_ack);
    if (e_entry) check("vector", pc_vector, e_vec);
    check("in_isr", in_isr, m_isr);
    check("active_id", active_id, m_aid);
    check("depth", depth, m_stack.size());
    check("error", error, m_err);
    s_push = stack_push; s_pop = stack_pop; s_sint = stack_interrupt;
    s_take = take_vector; s_vec = pc_vector; s_data = stack_data;
    s_ack = ack; s_isr = in_isr; s_err = error; s_depth = depth;
  endtask

  // driver task: one full clock cycle
  task automatic cycle(input logic r, input logic [3:0] i, input logic mwe,
                       input logic [3:0] md, input logic c, input logic rt,
                       input logic ri, input logic [9:0] pc);
    @(negedge clk);
    reset = r; irq = i; mask_we = mwe; mask_wdata = md;
    call = c; ret = rt; reti = ri; pc_addr = pc;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input logic [3:0] i);
    cycle(1'b0, i, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000);
  endtask

  task automatic do_reset();
    cycle(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000);
    cycle(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000);
  endtask

  initial begin
    reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
    call = 1'b0; ret = 1'b0; reti = 1'b0; pc_addr = '0;
    @(posedge clk);
    model_reset();
    do_reset();
    check("rst_depth", s_depth, 5'd0);
    check("rst_push", s_push, 1'b0);

    // single interrupt entry and reti
    cycle(1'b0, 4'h0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 10'h000);
    cycle(1'b0, 4'b0010, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h010);
    cycle(1'b0, 4'b0010, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h010);
    check("tp1_take", s_take, 1'b1);
    check("tp1_vec", s_vec, 10'h3D0);
    check("tp1_data", s_data, 10'h010);
    check("tp1_ack", s_ack, 4'b0010);
    cycle(1'b0, 4'b0010, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h3D0);
    check("tp1_isr", s_isr, 1'b1);
    check("tp1_depth", s_depth, 5'd1);
    check("tp1_pop", s_pop, 1'b1);
    check("tp1_sint", s_sint, 1'b1);
    idle(4'b0000);
    check("tp1_idle", s_isr, 1'b0);
    check("tp1_depth0", s_depth, 5'd0);

    // simultaneous irq0/irq2: priority then deferred second entry
    cycle(1'b0, 4'h0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 10'h020);
    idle(4'b0101);
    idle(4'b0101);
    check("tp2_vec0", s_vec, 10'h3C0);
    check("tp2_ack0", s_ack, 4'b0001);
    cycle(1'b0, 4'b0101, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h3C5);
    check("tp2_reti_take", s_take, 1'b0);
    idle(4'b0101);
    check("tp2_vec2", s_vec, 10'h3E0);
    check("tp2_ack2", s_ack, 4'b0100);
    cycle(1'b0, 4'b0101, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h3E1);
    idle(4'b0000);

    // call defers entry; nested call/ret inside ISR
    idle(4'b1000);
    cycle(1'b0, 4'b1000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h030);
    check("tp3_call_push", s_push, 1'b1);
    check("tp3_call_take", s_take, 1'b0);
    idle(4'b1000);
    check("tp3_take", s_take, 1'b1);
    check("tp3_depth1", s_depth, 5'd1);
    cycle(1'b0, 4'b1000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h3F0);
    cycle(1'b0, 4'b1000, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 10'h100);
    check("tp3_ret_pop", s_pop, 1'b1);
    check("tp3_ret_sint", s_sint, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h3F1);
    check("tp3_reti_pop", s_pop, 1'b1);
    cycle(1'b0, 4'b1000, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 10'h031);
    idle(4'b0000);
    check("tp3_depth0", s_depth, 5'd0);
    check("tp3_noerr", s_err, 1'b0);

    // full stack blocks entry; overflow call sets error
    do_reset();
    cycle(1'b0, 4'h0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 10'h000);
    for (int k = 0; k < 16; k++)
      cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 10'(k));
    idle(4'b0001);
    idle(4'b0001);
    check("tp4_full_take", s_take, 1'b0);
    check("tp4_full_depth", s_depth, 5'd16);
    cycle(1'b0, 4'b0001, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h050);
    check("tp4_ovf_push", s_push, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 10'h051);
    check("tp4_err", s_err, 1'b1);
    check("tp4_ret_pop", s_pop, 1'b1);
    idle(4'b0001);
    check("tp4_take", s_take, 1'b1);
    cycle(1'b0, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h3C0);

    // masked request, then unmask; reti while idle
    do_reset();
    cycle(1'b0, 4'h0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 10'h000);
    idle(4'b0100);
    idle(4'b0100);
    check("tp5_masked_ack", s_ack, 4'b0000);
    cycle(1'b0, 4'b0100, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 10'h060);
    check("tp5_mwr_take", s_take, 1'b0);
    idle(4'b0100);
    check("tp5_ack", s_ack, 4'b0100);
    cycle(1'b0, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h3E0);
    cycle(1'b0, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h061);
    check("tp5_idle_reti_pop", s_pop, 1'b0);
    idle(4'b0000);
    check("tp5_err", s_err, 1'b1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic       r_rst, r_mwe, r_c, r_rt, r_ri;
      logic [3:0] r_irq, r_md;
      int         op;
      r_rst = ($urandom_range(0, 299) == 0);
      r_irq = irq;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
      r_mwe = ($urandom_range(0, 19) == 0);
      r_md  = 4'($urandom_range(0, 15));
      op    = $urandom_range(0, 99);
      r_c = 1'b0; r_rt = 1'b0; r_ri = 1'b0;
      if (op >= 45 && op < 70)      r_c  = 1'b1;
      else if (op >= 70 && op < 82) r_rt = 1'b1;
      else if (op >= 82 && op < 94) r_ri = 1'b1;
      else if (op >= 94) begin
        r_c = 1'($urandom_range(0, 1)); r_rt = 1'($urandom_range(0, 1));
        r_ri = 1'($urandom_range(0, 1));
      end
      cycle(r_rst, r_irq, r_mwe, r_md, r_c, r_rt, r_ri, 10'($urandom_range(0, 1023)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
